// File: rtl/mult_pkg.sv
// Shared definitions for the HI/LO multiply sequencer and the CPU control unit.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_SETTLE = 2'd3
    } mult_state_e;

    localparam logic [5:0] TIMEOUT_DEF = 6'd63;

endpackage

// File: rtl/mult_sequencer.sv
// Drives the external unsigned multiplier for MULT/MULTU and owns the HI/LO registers.
// Signed operands are reduced to magnitudes; the sign is reapplied to the 64-bit product.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_signed,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wr_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_product,
    input  logic        mul_ready
);

    // Abort fires on the edge that ends the TIMEOUT-th WAIT cycle.
    localparam logic [5:0] WAIT_LAST = 6'(TIMEOUT - 1);

    mult_state_e state_q;
    logic [31:0] hi_q, lo_q, mul_a_q, mul_b_q;
    logic        mul_start_q, done_q, err_q, neg_q;
    logic [5:0]  wcnt_q;

    logic [31:0] abs_a_d, abs_b_d;
    logic [63:0] prod_d;

    // 32'h80000000 negates to itself, which reads correctly as unsigned 2^31.
    assign abs_a_d = req_a[31] ? (~req_a + 32'd1) : req_a;
    assign abs_b_d = req_b[31] ? (~req_b + 32'd1) : req_b;
    assign prod_d  = neg_q ? (~mul_product + 64'd1) : mul_product;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            neg_q       <= 1'b0;
            wcnt_q      <= '0;
        end else begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mul_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (hi_we) hi_q <= wr_data;
                    if (lo_we) lo_q <= wr_data;
                    if (req_valid) begin
                        mul_a_q     <= req_signed ? abs_a_d : req_a;
                        mul_b_q     <= req_signed ? abs_b_d : req_b;
                        neg_q       <= req_signed & (req_a[31] ^ req_b[31]);
                        mul_start_q <= 1'b1;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    wcnt_q  <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Only here is mul_ready trusted; it may still be high from the last op.
                    if (mul_ready) begin
                        state_q <= ST_SETTLE;
                    end else if (wcnt_q == WAIT_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + 6'd1;
                    end
                end
                ST_SETTLE: begin
                    {hi_q, lo_q} <= prod_d;
                    done_q       <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 63, meaning the maximum number of WAIT cycles before the block aborts.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 req_valid  in  1  the CPU control unit requests a multiply.
REQ-005 req_signed  in  1  1 = MULT (two's complement), 0 = MULTU.
REQ-006 req_a, req_b  in  32 each  operands.
REQ-007 req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid & req_ready.
REQ-008 busy  out  1  high in every state except IDLE; the CPU stalls on it.
REQ-009 done  out  1  one-cycle pulse when hi/lo hold a new product.
REQ-010 err  out  1  one-cycle pulse on timeout abort.
REQ-011 hi_we, lo_we  in  1 each  MTHI/MTLO write strobes; wr_data  in  32  write value.
REQ-012 hi, lo  out  32 each  the HI/LO architectural registers, always readable (MFHI/MFLO).
REQ-013 mul_start  out  1; mul_a, mul_b  out  32 each  these drive the team's unsigned multiplier.
REQ-014 mul_product  in  64; mul_ready  in  1  these come from the multiplier.

Function
REQ-015 The FSM SHALL use states IDLE, LOAD, WAIT and SETTLE.
- IDLE->LOAD on acceptance.
- LOAD->WAIT unconditionally.
- WAIT->SETTLE on mul_ready=1.
- WAIT->IDLE on timeout.
- SETTLE->IDLE unconditionally.
REQ-016 On acceptance, the block SHALL register mul_a=|req_a| and mul_b=|req_b| when req_signed=1, and the raw operands otherwise, together with neg=req_signed&(req_a[31]^req_b[31]).
REQ-017 |x| of 32'h80000000 SHALL be 32'h80000000, interpreted as unsigned 2^31.
REQ-018 mul_start SHALL be 1 exactly during the LOAD cycle and 0 in every other state.
REQ-019 mul_ready SHALL be ignored outside WAIT, because a stale ready from a previous operation is possible during LOAD.
REQ-020 In SETTLE, {hi,lo} SHALL load neg ? (~mul_product+1) : mul_product, with 64-bit two's-complement negation.
REQ-021 done SHALL be registered and high for the single cycle after the SETTLE edge.
REQ-022 With the team multiplier, done SHALL rise 35 cycles after the accepting edge.
REQ-023 A 6-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-024 If the wait counter reaches TIMEOUT with mul_ready=0, the block SHALL pulse err, return to IDLE and leave hi/lo unchanged.
REQ-025 hi_we/lo_we SHALL write hi/lo in IDLE only, and SHALL be ignored while busy.
REQ-026 A write on the accepting edge SHALL take effect; the later SETTLE capture then overwrites it.
REQ-027 req_valid while busy SHALL be ignored and not queued.
REQ-028 req_a/req_b SHALL be sampled only on the accepting edge and may change afterwards.

Reset
REQ-029 When rst_n=0, the block SHALL immediately force: state=IDLE, hi=lo=0, mul_a=mul_b=0, mul_start=0, done=err=0, neg=0, wait counter=0.
REQ-030 Reset mid-operation SHALL abort without a done pulse; the first request after rst_n rises SHALL complete normally.

Structure
REQ-031 The state encodings and the 6-bit TIMEOUT default SHALL live in a shared package, mult_pkg, for reuse by the CPU control unit.
REQ-032 No sub-module SHALL be used; the absolute-value logic and 64-bit negation SHALL stay inline.
REQ-033 The existing multiplier SHALL be instantiated beside the block in the datapath, not inside it.

Verification
REQ-034 The bench SHALL use the real multiplier and cover these scenarios:
- MULTU a=32'hFFFFFFFF, b=2 -> done at +35, hi=1, lo=32'hFFFFFFFE.
- MULT a=-3, b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- MULT a=32'h80000000, b=32'h80000000 -> hi=32'h40000000, lo=0.
- req_valid held high through busy, plus hi_we in WAIT -> one product only; write ignored; req_ready=0 throughout.
- Multiplier replaced by a stub with mul_ready stuck 0 -> err pulse after 63 WAIT cycles, hi/lo unchanged, req_ready=1 next cycle.
- rst_n pulsed low in WAIT -> hi=lo=0 and mul_start=0 immediately, no done; next MULTU 5*6 gives lo=30.
